// File: rtl/pkt_write_arbiter_if.sv
// Bundle of ingress request/data lanes, SRAM free-space report and the
// arbitrated write stream. The arbiter sits on the slave side.
interface pkt_write_arbiter_if;
    logic [15:0]  port_req;
    logic [111:0] port_pages;
    logic [63:0]  port_dest;
    logic [15:0]  port_vld;
    logic [255:0] port_data;
    logic [15:0]  port_eop;
    logic [10:0]  free_space;

    logic [15:0]  grant;
    logic         xfer_data_vld;
    logic [15:0]  xfer_data;
    logic         end_of_packet;
    logic [3:0]   cur_dest_port;
    logic [10:0]  cur_length;
    logic         truncated;

    modport master (
        output port_req, port_pages, port_dest, port_vld, port_data, port_eop, free_space,
        input  grant, xfer_data_vld, xfer_data, end_of_packet, cur_dest_port, cur_length, truncated
    );

    modport slave (
        input  port_req, port_pages, port_dest, port_vld, port_data, port_eop, free_space,
        output grant, xfer_data_vld, xfer_data, end_of_packet, cur_dest_port, cur_length, truncated
    );
endinterface

// File: rtl/pkt_write_arbiter.sv
// Round-robin arbiter granting one ingress port at a time to the SRAM write
// side, forwarding its words and force-terminating packets that overrun.
//   state | meaning
//   IDLE  | search for an eligible requester starting at rr_ptr
//   XFER  | forward granted port's words, count against pages*8
//   GAP   | IDLE_GAP quiet cycles after end_of_packet
module pkt_write_arbiter #(
    parameter int IDLE_GAP = 2
) (
    input  logic               clk,
    input  logic               rst,
    pkt_write_arbiter_if.slave bus
);
    localparam int GW = (IDLE_GAP < 2) ? 1 : $clog2(IDLE_GAP + 1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(IDLE_GAP);

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t        state;
    logic [3:0]    rr_ptr;
    logic [3:0]    gnt_idx;
    logic [9:0]    word_cnt;
    logic [9:0]    limit_q;
    logic [GW-1:0] gap_cnt;

    logic [15:0]   eligible;
    logic          found;
    logic [3:0]    sel;
    logic [3:0]    idx;
    logic          g_vld;
    logic          g_eop;
    logic [15:0]   g_data;
    logic [9:0]    cnt_next;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < 16; i++) begin
            eligible[i] = bus.port_req[i]
                        && (bus.port_pages[7*i +: 7] != 7'd0)
                        && ({4'b0000, bus.port_pages[7*i +: 7]} <= bus.free_space);
        end
    end

    // 4-bit index arithmetic gives the modulo-16 wrap for free.
    always_comb begin
        found = 1'b0;
        sel   = rr_ptr;
        idx   = rr_ptr;
        for (int k = 0; k < 16; k++) begin
            idx = rr_ptr + 4'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign g_vld    = bus.port_vld[gnt_idx];
    assign g_eop    = bus.port_eop[gnt_idx];
    assign g_data   = bus.port_data[16*gnt_idx +: 16];
    assign cnt_next = word_cnt + 10'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            gnt_idx           <= '0;
            word_cnt          <= '0;
            limit_q           <= '0;
            gap_cnt           <= '0;
            bus.grant         <= '0;
            bus.xfer_data_vld <= 1'b0;
            bus.xfer_data     <= '0;
            bus.end_of_packet <= 1'b0;
            bus.truncated     <= 1'b0;
            bus.cur_dest_port <= '0;
            bus.cur_length    <= '0;
        end else begin
            bus.xfer_data_vld <= 1'b0;
            bus.xfer_data     <= '0;
            bus.end_of_packet <= 1'b0;
            bus.truncated     <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.grant         <= 16'd1 << sel;
                        bus.cur_dest_port <= bus.port_dest[4*sel +: 4];
                        bus.cur_length    <= {4'b0000, bus.port_pages[7*sel +: 7]};
                        limit_q           <= {bus.port_pages[7*sel +: 7], 3'b000};
                        gnt_idx           <= sel;
                        rr_ptr            <= sel + 4'd1;
                        word_cnt          <= '0;
                        state             <= XFER;
                    end
                end
                XFER: begin
                    if (g_vld) begin
                        bus.xfer_data_vld <= 1'b1;
                        bus.xfer_data     <= g_data;
                        word_cnt          <= cnt_next;
                        // Limit hit without eop means the source overran its page budget.
                        if (g_eop || (cnt_next == limit_q)) begin
                            bus.end_of_packet <= 1'b1;
                            bus.truncated     <= !g_eop;
                            bus.grant         <= '0;
                            gap_cnt           <= GAP_LOAD;
                            state             <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_write_arbiter.sv
// Directed plus randomized bench for pkt_write_arbiter; expectations come from
// a packet-level model of eligibility, round-robin order and page limits.
module tb_pkt_write_arbiter;
    localparam int GAP = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pkt_write_arbiter_if bus();

    pkt_write_arbiter #(.IDLE_GAP(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    bit cfg_req[16];
    int cfg_pages[16];
    int cfg_dest[16];
    int cfg_free;
    int rr_model;
    int last_dest;
    int last_len;
    int cur_port;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        for (int i = 0; i < 16; i++) begin
            cfg_req[i]   = 1'b0;
            cfg_pages[i] = 0;
            cfg_dest[i]  = 0;
        end
        cfg_free = 2047;
    endtask

    task automatic apply_cfg();
        for (int i = 0; i < 16; i++) begin
            bus.port_req[i]           = cfg_req[i];
            bus.port_pages[7*i +: 7]  = 7'(cfg_pages[i]);
            bus.port_dest[4*i +: 4]   = 4'(cfg_dest[i]);
        end
        bus.free_space = 11'(cfg_free);
    endtask

    task automatic drive_noise();
        for (int i = 0; i < 16; i++) begin
            bus.port_vld[i]           = 1'($urandom_range(1));
            bus.port_eop[i]           = 1'($urandom_range(1));
            bus.port_data[16*i +: 16] = 16'($urandom);
        end
    endtask

    task automatic perturb_cfg();
        bus.port_req = 16'($urandom);
        for (int i = 0; i < 16; i++) bus.port_pages[7*i +: 7] = 7'($urandom);
        bus.free_space = 11'($urandom);
    endtask

    // First requester at or after rr_model (mod 16) whose nonzero length fits.
    function automatic int exp_winner();
        for (int k = 0; k < 16; k++) begin
            int p;
            p = (rr_model + k) % 16;
            if (cfg_req[p] && cfg_pages[p] != 0 && cfg_pages[p] <= cfg_free) return p;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(bus.grant), 0);
        chk({tag, "_vld"},   32'(bus.xfer_data_vld), 0);
        chk({tag, "_data"},  32'(bus.xfer_data), 0);
        chk({tag, "_eop"},   32'(bus.end_of_packet), 0);
        chk({tag, "_trunc"}, 32'(bus.truncated), 0);
        chk({tag, "_dest"},  32'(bus.cur_dest_port), 0);
        chk({tag, "_len"},   32'(bus.cur_length), 0);
    endtask

    // Idle/gap cycles until a grant shows; returns budget+1 if none appears.
    task automatic wait_grant(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            drive_noise();
            @(negedge clk);
            cyc++;
            if (bus.grant != 16'd0) return;
            chk("quiet_vld",   32'(bus.xfer_data_vld), 0);
            chk("quiet_eop",   32'(bus.end_of_packet), 0);
            chk("quiet_trunc", 32'(bus.truncated), 0);
            chk("quiet_dest",  32'(bus.cur_dest_port), 32'(last_dest));
            chk("quiet_len",   32'(bus.cur_length), 32'(last_len));
        end
        cyc = budget + 1;
    endtask

    task automatic arb(input string tag, input int exp_cyc);
        int p;
        int cyc;
        p = exp_winner();
        wait_grant(exp_cyc + 8, cyc);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
        if (p >= 0) begin
            chk({tag, "_grant"}, 32'(bus.grant), 32'd1 << p);
            chk({tag, "_dest"},  32'(bus.cur_dest_port), 32'(cfg_dest[p]));
            chk({tag, "_len"},   32'(bus.cur_length), 32'(cfg_pages[p]));
            last_dest = cfg_dest[p];
            last_len  = cfg_pages[p];
            rr_model  = (p + 1) % 16;
            cur_port  = p;
        end
    endtask

    task automatic expect_none(input string tag, input int ncyc);
        int cyc;
        wait_grant(ncyc, cyc);
        chk({tag, "_no_grant"}, 32'(cyc), 32'(ncyc + 1));
    endtask

    // Feed nwords on the granted port; every output cycle is checked against
    // the word driven one cycle earlier. Returns at the end_of_packet cycle.
    task automatic stream(input string tag, input int nwords, input bit give_eop, input int bubble_pct);
        int p, limit, sent, acc, budget;
        bit done, v, e, ev, eeop, etr;
        logic [15:0] d, ed;
        p      = cur_port;
        limit  = cfg_pages[p] * 8;
        sent   = 0;
        acc    = 0;
        done   = 1'b0;
        budget = nwords * 4 + 40;
        while (!done && budget > 0) begin
            budget--;
            drive_noise();
            perturb_cfg();
            v = (sent < nwords) && ($urandom_range(99) >= bubble_pct);
            e = v && give_eop && (sent + 1 == nwords);
            d = 16'($urandom);
            bus.port_vld[p]           = v;
            bus.port_eop[p]           = e;
            bus.port_data[16*p +: 16] = d;
            ev = v; ed = d; eeop = 1'b0; etr = 1'b0;
            if (v) begin
                sent++;
                acc++;
                eeop = e || (acc == limit);
                etr  = eeop && !e;
            end
            @(negedge clk);
            chk({tag, "_vld"}, 32'(bus.xfer_data_vld), 32'(ev));
            if (ev) chk({tag, "_data"}, 32'(bus.xfer_data), 32'(ed));
            chk({tag, "_eop"},   32'(bus.end_of_packet), 32'(eeop));
            chk({tag, "_trunc"}, 32'(bus.truncated), 32'(etr));
            chk({tag, "_grant"}, 32'(bus.grant), eeop ? 32'd0 : (32'd1 << p));
            chk({tag, "_dest_hold"}, 32'(bus.cur_dest_port), 32'(last_dest));
            chk({tag, "_len_hold"},  32'(bus.cur_length), 32'(last_len));
            if (eeop) done = 1'b1;
        end
        chk({tag, "_completed"}, 32'(done), 1);
        apply_cfg();
    endtask

    initial begin
        int q, lim, nw;
        bit ge;

        rst = 1'b1;
        bus.port_req   = '0;
        bus.port_pages = '0;
        bus.port_dest  = '0;
        bus.port_vld   = '0;
        bus.port_data  = '0;
        bus.port_eop   = '0;
        bus.free_space = '0;
        clear_cfg();
        rr_model = 0; last_dest = 0; last_len = 0; cur_port = 0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // Round robin between ports 0 and 15.
        cfg_req[0] = 1'b1; cfg_pages[0] = 2; cfg_dest[0] = 10;
        cfg_req[15] = 1'b1; cfg_pages[15] = 2; cfg_dest[15] = 3;
        cfg_free = 2047;
        apply_cfg();
        rst = 1'b0;
        arb("rr_a", 1);
        stream("rr_a", 16, 1'b1, 20);
        arb("rr_b", GAP + 2);
        stream("rr_b", 16, 1'b1, 20);
        arb("rr_c", GAP + 2);
        stream("rr_c", 16, 1'b1, 0);

        // Normal 8-word packet on port 3.
        clear_cfg();
        cfg_req[3] = 1'b1; cfg_pages[3] = 1; cfg_dest[3] = 9;
        apply_cfg();
        arb("norm", GAP + 2);
        stream("norm", 8, 1'b1, 30);

        // Overrun on port 5: 10 words without eop, words 9-10 must vanish.
        clear_cfg();
        cfg_req[5] = 1'b1; cfg_pages[5] = 1; cfg_dest[5] = 6;
        apply_cfg();
        arb("trunc", GAP + 2);
        stream("trunc", 10, 1'b0, 0);
        clear_cfg();
        apply_cfg();
        for (int k = 0; k < 2; k++) begin
            bus.port_vld[5] = 1'b1;
            bus.port_eop[5] = 1'b0;
            bus.port_data[80 +: 16] = 16'($urandom);
            @(negedge clk);
            chk("drop_vld",   32'(bus.xfer_data_vld), 0);
            chk("drop_grant", 32'(bus.grant), 0);
        end
        expect_none("trunc_after", 6);

        // Space gate.
        cfg_req[2] = 1'b1; cfg_pages[2] = 4; cfg_dest[2] = 1;
        cfg_req[7] = 1'b1; cfg_pages[7] = 3; cfg_dest[7] = 2;
        cfg_free = 3;
        apply_cfg();
        arb("space_a", 1);
        stream("space_a", 24, 1'b1, 10);
        cfg_free = 2;
        apply_cfg();
        expect_none("space_low", 12);
        cfg_free = 4;
        apply_cfg();
        arb("space_b", 1);
        stream("space_b", 32, 1'b1, 10);

        // Zero-length requester, then reset in the middle of a transfer.
        clear_cfg();
        cfg_req[1] = 1'b1; cfg_pages[1] = 0; cfg_dest[1] = 5;
        apply_cfg();
        expect_none("zero_len", GAP + 8);
        cfg_req[2] = 1'b1; cfg_pages[2] = 2; cfg_dest[2] = 12;
        apply_cfg();
        arb("pre_rst", 1);
        for (int k = 0; k < 3; k++) begin
            bus.port_vld[2] = 1'b1;
            bus.port_eop[2] = 1'b0;
            bus.port_data[32 +: 16] = 16'($urandom);
            @(negedge clk);
            chk("pre_rst_vld", 32'(bus.xfer_data_vld), 1);
        end
        rst = 1'b1;
        bus.port_eop[2] = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        @(negedge clk);
        check_all_zero("mid_rst2");
        rr_model = 0; last_dest = 0; last_len = 0;
        clear_cfg();
        cfg_req[1] = 1'b1; cfg_pages[1] = 0;
        cfg_req[0] = 1'b1; cfg_pages[0] = 1; cfg_dest[0] = 7;
        cfg_req[9] = 1'b1; cfg_pages[9] = 1; cfg_dest[9] = 4;
        apply_cfg();
        rst = 1'b0;
        arb("post_rst", 1);
        stream("post_rst", 8, 1'b1, 0);

        // Randomized packets.
        for (int n = 0; n < 25; n++) begin
            clear_cfg();
            for (int i = 0; i < 16; i++) begin
                cfg_req[i]   = ($urandom_range(2) == 0);
                cfg_pages[i] = ($urandom_range(15) == 0) ? 64 : int'($urandom_range(4));
                cfg_dest[i]  = int'($urandom_range(15));
            end
            cfg_free = ($urandom_range(1) == 0) ? 2047 : int'($urandom_range(6));
            if (exp_winner() < 0) begin
                q = int'($urandom_range(15));
                cfg_req[q]   = 1'b1;
                cfg_pages[q] = int'($urandom_range(4, 1));
                cfg_free     = 2047;
            end
            apply_cfg();
            arb("rand", GAP + 2);
            lim = cfg_pages[cur_port] * 8;
            ge  = 1'($urandom_range(1));
            nw  = ge ? int'($urandom_range(lim, 1)) : lim + int'($urandom_range(3));
            stream("rand", nw, ge, int'($urandom_range(40)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
